// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  localparam int UART_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// First set req bit at or after ptr, searching cyclically.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic found;
  int   idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among N byte producers
// Round-robin grant with bursts of up to MAX_BURST frames per owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int WIDTH     = UART_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CLIENTS-1:0]         req,
  input  logic [N_CLIENTS*WIDTH-1:0]   data,
  output logic [N_CLIENTS-1:0]         ack,
  output logic                         tx_send,
  output logic [WIDTH-1:0]             tx_data,
  input  logic                         tx_ready,
  output logic [$clog2(N_CLIENTS)-1:0] owner,
  output logic                         busy
);

  localparam int IW = $clog2(N_CLIENTS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_CLIENTS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [BW-1:0]    r_burst;
  logic [WIDTH-1:0] r_tx_data;

  logic [IW-1:0]    w_winner;
  logic             w_valid;
  logic             w_owner_req;
  logic [WIDTH-1:0] w_owner_data;
  logic [WIDTH-1:0] w_win_data;
  logic [IW-1:0]    w_next_ptr;
  logic             w_load_win;
  logic             w_load_next;
  logic             w_rotate;

  rr_pick #(.N(N_CLIENTS)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  assign w_owner_req  = req[r_owner];
  assign w_owner_data = data[int'(r_owner)*WIDTH +: WIDTH];
  assign w_win_data   = data[int'(w_winner)*WIDTH +: WIDTH];
  assign w_next_ptr   = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // DRAIN waits for the transmitter to drop ready so a frame is never sent twice.
  always_comb begin
    w_next_state = r_state;
    ack          = '0;
    tx_send      = 1'b0;
    w_load_win   = 1'b0;
    w_load_next  = 1'b0;
    w_rotate     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_load_win   = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!w_owner_req) begin
          w_next_state = IDLE;
        end else if (tx_ready) begin
          tx_send      = 1'b1;
          ack[r_owner] = 1'b1;
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_ready) w_next_state = WAIT;
      end
      WAIT: begin
        if (tx_ready) begin
          if (w_owner_req && (r_burst < BURST_MAX)) begin
            w_load_next  = 1'b1;
            w_next_state = ISSUE;
          end else begin
            w_rotate     = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_burst   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_load_win) begin
        r_owner   <= w_winner;
        r_tx_data <= w_win_data;
        r_burst   <= BURST_ONE;
      end
      if (w_load_next) begin
        r_tx_data <= w_owner_data;
        r_burst   <= r_burst + BURST_ONE;
      end
      if (w_rotate) r_ptr <= w_next_ptr;
    end
  end

  assign tx_data = r_tx_data;
  assign owner   = r_owner;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Behavioural 10-bit UART transmitter plus a transaction-level grant model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]  ack;
  logic          tx_send;
  logic [W-1:0]  tx_data;
  logic          tx_ready;
  logic [1:0]    owner;
  logic          busy;

  uart_tx_arbiter #(.N_CLIENTS(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Transmitter: start bit, 8 data bits LSB first, stop bit; one bit per clock.
  logic       m_ready = 1'b1;
  logic [9:0] m_sh    = '1;
  logic [3:0] m_cnt   = '0;
  logic       m_line;
  logic       hold    = 1'b0;

  assign tx_ready = m_ready & ~hold;
  assign m_line   = m_ready ? 1'b1 : m_sh[m_cnt];

  always @(posedge clk) begin
    if (m_ready) begin
      if (tx_send) begin
        m_ready <= 1'b0;
        m_sh    <= {1'b1, tx_data, 1'b0};
        m_cnt   <= '0;
      end
    end else if (m_cnt == 4'd9) begin
      m_ready <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  typedef struct {
    int         client;
    logic [7:0] byte_v;
  } exp_t;

  logic [7:0] cq [N][$];
  logic [N-1:0] mask = '1;
  logic hold_cmd  = 1'b0;
  logic rand_hold = 1'b0;
  exp_t exp_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_q[$];
  logic [N-1:0] ack_seen = '0;
  logic [9:0] frame_bits = '0;
  logic [9:0] last_frame = '0;
  int m_ptr   = 0;
  int m_owner = 0;
  int total   = 0;
  int bad     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = mask[i] && (cq[i].size() > 0);
      data[i*W +: W] = (cq[i].size() > 0) ? cq[i][0] : 8'h00;
    end
    hold = rand_hold ? ($urandom_range(0, 3) == 0) : hold_cmd;
  endtask

  // Grant order from the rules: cyclic search from the pointer, up to MB words, rotate.
  task automatic build_model();
    int rem[N];
    int pos[N];
    int w;
    int k;
    int c;
    for (int i = 0; i < N; i++) begin
      rem[i] = mask[i] ? cq[i].size() : 0;
      pos[i] = 0;
    end
    while (1) begin
      w = -1;
      for (int j = 0; j < N; j++) begin
        c = (m_ptr + j) % N;
        if (w < 0 && rem[c] > 0) w = c;
      end
      if (w < 0) break;
      k = (rem[w] < MB) ? rem[w] : MB;
      for (int j = 0; j < k; j++) begin
        exp_t e;
        e.client = w;
        e.byte_v = cq[w][pos[w]];
        exp_q.push_back(e);
        exp_bytes.push_back(e.byte_v);
        pos[w]++;
        rem[w]--;
      end
      m_owner = w;
      m_ptr   = (w + 1) % N;
    end
  endtask

  task automatic tick();
    logic [3:0] em;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (ack_seen[i] && cq[i].size() > 0) void'(cq[i].pop_front());
    drive();
    @(negedge clk);
    ack_seen = ack;
    chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
    chk("send_vs_ack", 32'(tx_send), 32'(|ack));
    if (tx_send) chk("send_needs_ready", 32'(tx_ready), 32'd1);
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e  = exp_q.pop_front();
        em = 4'b0001 << e.client;
        chk("ack_client", 32'(ack), 32'(em));
        chk("ack_data", 32'(tx_data), 32'(e.byte_v));
      end
    end
    if (!m_ready) begin
      frame_bits[m_cnt] = m_line;
      if (m_cnt == 4'd9) begin
        last_frame = frame_bits;
        rx_q.push_back(frame_bits[8:1]);
      end
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (mask[i] && cq[i].size() > 0) return 1'b0;
    return !busy && m_ready && (exp_q.size() == 0);
  endfunction

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    while (!all_done() && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 4000), 32'd1);
    chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
      chk({tag, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_bytes[i]));
    rx_q.delete();
    exp_bytes.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int words;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_send", 32'(tx_send), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);

    // Single word from client 2
    cq[2].push_back(8'hA5);
    build_model();
    drive();
    tick();
    chk("t1_first_ack", 32'(ack), 32'h4);
    chk("t1_owner", 32'(owner), 32'd2);
    run_until_idle("t1");
    chk("t1_line", 32'(last_frame), 32'h34A);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_owner_after", 32'(owner), 32'd2);

    // Reset inside WAIT of a client-3 burst
    for (int i = 0; i < 4; i++) cq[3].push_back(8'(8'h30 + i));
    build_model();
    drive();
    repeat (4) tick();
    chk("t5_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_send", 32'(tx_send), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) cq[i].delete();
    exp_q.delete();
    ack_seen = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_owner", 32'(owner), 32'd0);
    m_ptr = 0;
    n = 0;
    while (!m_ready && n < 50) begin
      tick();
      n++;
    end
    chk("t5_tx_idle", 32'(m_ready), 32'd1);
    rx_q.delete();
    exp_bytes.delete();
    cq[0].push_back(8'h5A);
    cq[3].push_back(8'hC3);
    build_model();
    drive();
    run_until_idle("t5_ptr");
    chk("t5_owner_after", 32'(owner), 32'(m_owner));

    // All four clients requesting continuously
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 5; j++) cq[i].push_back(8'((i << 4) | j));
    build_model();
    drive();
    run_until_idle("t2");
    chk("t2_owner", 32'(owner), 32'(m_owner));

    // Client 0 drops its request during DRAIN while client 3 waits
    cq[0].push_back(8'h11);
    cq[0].push_back(8'h12);
    cq[0].push_back(8'h13);
    cq[3].push_back(8'h33);
    begin
      exp_t e;
      e.client = 0; e.byte_v = 8'h11; exp_q.push_back(e); exp_bytes.push_back(8'h11);
      e.client = 3; e.byte_v = 8'h33; exp_q.push_back(e); exp_bytes.push_back(8'h33);
    end
    drive();
    tick();
    chk("t4_first_ack", 32'(ack), 32'h1);
    tick();
    mask[0] = 1'b0;
    drive();
    run_until_idle("t4");
    chk("t4_owner", 32'(owner), 32'd3);
    cq[0].delete();
    mask[0] = 1'b1;
    m_ptr = 0;

    // Client 1 alone, six words: burst of 4 then regrant
    for (int j = 1; j <= 6; j++) cq[1].push_back(8'(j));
    build_model();
    drive();
    run_until_idle("t3");
    chk("t3_owner", 32'(owner), 32'd1);

    // Transmitter held not-ready while in ISSUE
    cq[2].push_back(8'h3C);
    hold_cmd = 1'b1;
    build_model();
    drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_send", 32'(tx_send), 32'd0);
      chk("t6_no_ack", 32'(ack), 32'd0);
    end
    hold_cmd = 1'b0;
    tick();
    chk("t6_send", 32'(tx_send), 32'd1);
    chk("t6_ack", 32'(ack), 32'h4);
    run_until_idle("t6");

    // Random loads with random transmitter stalls
    for (int t = 0; t < 6; t++) begin
      words = 0;
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 9);
        for (int j = 0; j < n; j++) cq[i].push_back(8'($urandom));
        words += n;
      end
      rand_hold = 1'b1;
      build_model();
      drive();
      run_until_idle("rnd");
      rand_hold = 1'b0;
      drive();
      if (words > 0) chk("rnd_owner", 32'(owner), 32'(m_owner));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
